zest_spi_cfg_master: RTL and testbench

ZEST_SPI_CFG_MASTER -- requirements
Module: zest_spi_cfg_master

---
 rtl/zest_spi_cfg_master.sv | 108 ++++++++++
 tb/tb_zest_spi_cfg_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/zest_spi_cfg_master.sv
// zest_spi_cfg_master: multi-target serial config master with 3/4-wire modes and per-device CS polarity
module zest_spi_cfg_master #(
    parameter int N_DEV = 6,
    parameter int DW = 32,
    parameter int CLK_DIV = 4,
    parameter logic [N_DEV-1:0] CS_ACT_HI = {N_DEV{1'b0}}
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     ready,
    input  logic [$clog2(N_DEV)-1:0] dev_sel,
    input  logic [$clog2(DW+1)-1:0]  len,
    input  logic [DW-1:0]            wdata,
    input  logic                     rd,
    input  logic                     mode_3w,
    input  logic [$clog2(DW+1)-1:0]  turn,
    output logic [N_DEV-1:0]         cs,
    output logic                     sclk,
    output logic                     mosi,
    output logic                     sdio_oe,
    input  logic                     sdio_i,
    input  logic [N_DEV-1:0]         miso,
    output logic [DW-1:0]            rdbk,
    output logic                     rdbk_valid,
    output logic                     err
);
    localparam int DVW = $clog2(N_DEV);
    localparam int LW = $clog2(DW+1);
    localparam int IW = DW > 1 ? $clog2(DW) : 1;
    localparam int CW = $clog2(CLK_DIV+1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
    state_t state, nxt;

    logic [CW-1:0]  cnt;
    logic           ph;
    logic [IW-1:0]  b;
    logic [LW-1:0]  len_q, turn_q, sent;
    logic [DW-1:0]  w_q;
    logic [DVW-1:0] dev_q;
    logic           rd_q, m3_q, bad, acc, tick, act, rel, line;

    assign tick = cnt == CW'(CLK_DIV-1);
    assign bad  = len == '0 || len > LW'(DW) || {1'b0, dev_sel} >= (DVW+1)'(N_DEV);
    assign acc  = state == IDLE && start && !bad;
    assign sent = len_q - LW'(1) - LW'(b);
    assign rel  = m3_q && rd_q && turn_q < len_q;
    assign line = m3_q ? sdio_i : miso[dev_q];

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = acc ? SETUP : IDLE;
            SETUP:   nxt = tick ? SHIFT : SETUP;
            SHIFT:   nxt = tick && ph && b == '0 ? HOLD : SHIFT;
            HOLD:    nxt = tick ? GAP : HOLD;
            GAP:     nxt = tick ? IDLE : GAP;
            default: nxt = IDLE;
        endcase
        act     = state == SETUP || state == SHIFT || state == HOLD;
        ready   = state == IDLE;
        sclk    = state == SHIFT && ph;
        mosi    = (state == SETUP || state == SHIFT) && w_q[b];
        cs      = ~CS_ACT_HI ^ (act ? N_DEV'(1) << dev_q : '0);
        // In a 3-wire read the line is released once bit turn-1 has been clocked out
        sdio_oe = act && (!rel || (state == SETUP ? turn_q != '0 : state == SHIFT && sent < turn_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ph         <= 1'b0;
            b          <= '0;
            len_q      <= '0;
            turn_q     <= '0;
            w_q        <= '0;
            dev_q      <= '0;
            rd_q       <= 1'b0;
            m3_q       <= 1'b0;
            rdbk       <= '0;
            rdbk_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= nxt;
            err        <= state == IDLE && start && bad;
            rdbk_valid <= state == GAP && tick;
            cnt        <= state == IDLE || tick ? '0 : cnt + CW'(1);
            if (acc) begin
                dev_q  <= dev_sel;
                len_q  <= len;
                turn_q <= turn;
                w_q    <= wdata;
                rd_q   <= rd;
                m3_q   <= mode_3w;
                b      <= IW'(len - LW'(1));
                ph     <= 1'b0;
                rdbk   <= '0;
            end
            if (state == SHIFT && tick) begin
                ph <= !ph;
                if (ph) b <= b - IW'(1);
            end
            if (state == SHIFT && tick && !ph) rdbk <= {rdbk[DW-2:0], line};
        end
    end
endmodule

// File: tb/tb_zest_spi_cfg_master.sv
// tb_zest_spi_cfg_master: directed vectors against hand-computed serial waveforms and readback
module tb_zest_spi_cfg_master;
    localparam int N = 6;
    localparam int DW = 32;
    localparam logic [5:0] HI = 6'b000001;
    localparam logic [5:0] IDLE_CS = 6'b111110;

    logic clk = 0, rst_n = 0, start = 0, rd = 0, mode_3w = 0;
    logic [2:0] dev_sel = 0;
    logic [5:0] len = 0, turn = 0;
    logic [31:0] wdata = 0;
    logic ready, sclk, mosi, sdio_oe, sdio_i, rdbk_valid, err;
    logic [5:0] cs, miso;
    logic [31:0] rdbk;

    zest_spi_cfg_master #(.N_DEV(N), .DW(DW), .CLK_DIV(2), .CS_ACT_HI(HI)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready), .dev_sel(dev_sel), .len(len),
        .wdata(wdata), .rd(rd), .mode_3w(mode_3w), .turn(turn), .cs(cs), .sclk(sclk), .mosi(mosi),
        .sdio_oe(sdio_oe), .sdio_i(sdio_i), .miso(miso), .rdbk(rdbk), .rdbk_valid(rdbk_valid), .err(err)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0;
    int cyc = 0, cs_cnt = 0, sck_cnt = 0, fall_cnt = 0, oe_cnt = 0, oe_drop = 0;
    int vld_cnt = 0, err_cnt = 0, rdy_low = 0, multi = 0, cs_on = 0, cs_off = 0, vld_cyc = 0;
    logic [5:0] cs_seen = 0, a;
    logic [31:0] mosi_sh = 0;
    logic sclk_p = 0, oe_p = 0, act_p = 0;

    int b_cs, b_sck, b_fall, b_oe, b_vld, b_err, b_rdy, b_multi;
    int fall_base = 0;
    logic [31:0] slv = 0;
    logic [2:0] sdev = 0;
    logic line;

    assign line   = (fall_cnt - fall_base) < 32 ? slv[31 - (fall_cnt - fall_base)] : 1'b0;
    assign miso   = line ? (6'b1 << sdev) : 6'b0;
    assign sdio_i = sdio_oe ? mosi : line;

    always @(negedge clk) begin
        a = cs ^ IDLE_CS;
        cyc++;
        if (a != 0) begin
            cs_cnt++;
            cs_seen = cs;
            if (!act_p) cs_on = cyc;
            if ($countones(a) != 1) multi++;
        end else if (act_p) cs_off = cyc;
        if (sclk && !sclk_p) begin
            sck_cnt++;
            mosi_sh = {mosi_sh[30:0], mosi};
        end
        if (!sclk && sclk_p) fall_cnt++;
        if (oe_p && !sdio_oe && a != 0) oe_drop = fall_cnt;
        if (sdio_oe) oe_cnt++;
        if (rdbk_valid) begin
            vld_cnt++;
            vld_cyc = cyc;
        end
        if (err) err_cnt++;
        if (!ready) rdy_low++;
        sclk_p = sclk;
        oe_p = sdio_oe;
        act_p = a != 0;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_cs = cs_cnt; b_sck = sck_cnt; b_fall = fall_cnt; b_oe = oe_cnt;
        b_vld = vld_cnt; b_err = err_cnt; b_rdy = rdy_low; b_multi = multi;
        fall_base = fall_cnt;
        oe_drop = 0;
    endtask

    task automatic launch(input int d, input int l, input logic [31:0] wd, input logic r,
                          input logic m3, input int tn, input logic [31:0] sv);
        snap();
        slv = sv;
        sdev = 3'(d);
        @(posedge clk); #1;
        dev_sel = 3'(d); len = 6'(l); wdata = wd; rd = r; mode_3w = m3; turn = 6'(tn); start = 1;
        @(posedge clk); #1;
        start = 0;
        dev_sel = 3'(5 - d); wdata = ~wd; len = 6'd1; rd = ~r; mode_3w = ~m3; turn = 6'd0;
    endtask

    task automatic wait_vld(input int n_exp);
        int n = 0;
        while (vld_cnt - b_vld < n_exp && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        check("timeout", n < 1000, 1);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic txn(input int d, input int l, input logic [31:0] wd, input logic r,
                       input logic m3, input int tn, input logic [31:0] sv);
        launch(d, l, wd, r, m3, tn, sv);
        wait_vld(1);
        check("vld_count", vld_cnt - b_vld, 1);
        check("one_hot_cs", multi - b_multi, 0);
    endtask

    task automatic rej(input int d, input int l);
        snap();
        @(posedge clk); #1;
        dev_sel = 3'(d); len = 6'(l); start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (4) @(negedge clk);
        #1;
        check("rej_err", err_cnt - b_err, 1);
        check("rej_cs", cs_cnt - b_cs, 0);
        check("rej_sclk", sck_cnt - b_sck, 0);
        check("rej_vld", vld_cnt - b_vld, 0);
        check("rej_ready", rdy_low - b_rdy, 0);
    endtask

    initial begin
        int n, off;
        #23;
        check("rst_ready", ready, 1);
        check("rst_cs", cs, IDLE_CS);
        check("rst_sig", {sclk, mosi, sdio_oe, rdbk_valid, err}, 0);
        check("rst_rdbk", rdbk, 0);
        @(negedge clk);
        rst_n = 1;

        txn(2, 24, 32'h801234, 0, 0, 0, 0);
        check("w_cs_len", cs_cnt - b_cs, 100);
        check("w_sclk", sck_cnt - b_sck, 24);
        check("w_mosi", mosi_sh[23:0], 24'h801234);
        check("w_cs_val", cs_seen, 6'b111010);
        check("w_vld_lat", vld_cyc - cs_off, 2);

        txn(3, 8, 32'h0, 1, 0, 0, 32'hA500_0000);
        check("r4_rdbk", rdbk, 32'h0000_00A5);
        check("r4_cs_len", cs_cnt - b_cs, 36);

        txn(1, 16, 32'h8300, 1, 1, 8, 32'h005C_0000);
        check("r3_oe_drop", oe_drop - b_fall, 8);
        check("r3_rdbk", rdbk, 32'h0000_835C);
        check("r3_mosi", mosi_sh[15:0], 16'h8300);

        txn(0, 8, 32'h3C, 0, 0, 0, 0);
        check("hi_cs_len", cs_cnt - b_cs, 36);
        check("hi_cs_val", cs_seen, 6'b111111);
        check("hi_mosi", mosi_sh[7:0], 8'h3C);

        txn(4, 8, 32'hFF, 1, 1, 0, 32'h6900_0000);
        check("t0_oe", oe_cnt - b_oe, 0);
        check("t0_rdbk", rdbk, 32'h69);

        txn(5, 4, 32'hA, 0, 1, 0, 0);
        check("w3_oe", oe_cnt - b_oe, 20);
        check("w3_mosi", mosi_sh[3:0], 4'hA);

        txn(2, 32, 32'hDEADBEEF, 1, 0, 0, 32'h1234_5678);
        check("full_rdbk", rdbk, 32'h1234_5678);
        check("full_mosi", mosi_sh, 32'hDEADBEEF);
        check("full_cs_len", cs_cnt - b_cs, 132);
        check("rdbk_hold", rdbk, 32'h1234_5678);

        rej(7, 8);
        rej(2, 0);
        rej(2, 33);

        snap();
        slv = 0;
        @(posedge clk); #1;
        dev_sel = 3'd4; len = 6'd4; wdata = 32'h5; rd = 0; mode_3w = 0; turn = 0; start = 1;
        n = 0;
        while (vld_cnt - b_vld < 1 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        off = cs_off;
        while (cs_on <= off && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        start = 0;
        check("b2b_gap", cs_on - off, 3);
        wait_vld(2);
        check("b2b_vld", vld_cnt - b_vld, 2);

        launch(2, 24, 32'h801234, 0, 0, 0, 0);
        n = 0;
        while (sck_cnt - b_sck < 5 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        check("rst_wait", n < 1000, 1);
        rst_n = 0;
        #1;
        check("arst_cs", cs, IDLE_CS);
        check("arst_sig", {sclk, sdio_oe, mosi}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        #1;
        check("arst_no_vld", vld_cnt - b_vld, 0);

        txn(3, 8, 32'h0, 1, 0, 0, 32'hC300_0000);
        check("post_rst_rdbk", rdbk, 32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
